// File: rtl/adder_arbiter.sv
// Two-requester front end serialising signed add/sub operations onto one shared adder.
// IDLE accepts (round-robin on contention), EXEC computes from registered operands, RESP holds the result.
module adder_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_add_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_add_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_overflow,
  output logic             rsp_negative,
  output logic             rsp_zero,
  output logic             rsp_cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sub_q, sub_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;

  logic             gnt0, gnt1, in_idle;
  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   sum;

  // Ready is gated by rst so nothing can be accepted while reset is held.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || !ptr_q);
    gnt1       = req1_valid && (!req0_valid ||  ptr_q);
    in_idle    = (state_q == IDLE) && !rst;
    req0_ready = in_idle && gnt0;
    req1_ready = in_idle && gnt1;
  end

  // Subtract is x + ~y + 1, so the carry-in is the op-select bit.
  always_comb begin
    y_eff = sub_q ? ~y_q : y_q;
    sum   = {1'b0, x_q} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub_q};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    sub_d       = sub_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    ovf_d       = ovf_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = EXEC;
          ptr_d   = req0_ready;
          x_d     = req1_ready ? req1_x       : req0_x;
          y_d     = req1_ready ? req1_y       : req0_y;
          sub_d   = req1_ready ? req1_add_sub : req0_add_sub;
          id_d    = req1_ready;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_s_d     = sum[WIDTH-1:0];
        cout_d      = sum[WIDTH];
        neg_d       = sum[WIDTH-1];
        zero_d      = ~|sum[WIDTH-1:0];
        ovf_d       = (x_q[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sub_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= '0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sub_q       <= sub_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      ovf_q       <= ovf_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_s        = rsp_s_q;
  assign rsp_overflow = ovf_q;
  assign rsp_negative = neg_q;
  assign rsp_zero     = zero_q;
  assign rsp_cout     = cout_q;

endmodule
